// File: rtl/mcp3008_pkg.sv
// mcp3008_pkg
// Shared types and constants for the MCP3008 round-robin scanner:
// FSM state encoding, frame bit positions, data widths and the
// command-bit helper used to serialise the start/SGL/channel field.
// Optional feature macro used elsewhere: MCP3008_AVG_EN.
package mcp3008_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCLK_HI,
    ST_SCLK_LO,
    ST_GAP
  } state_e;

  localparam int FRAME_BITS     = 17;
  localparam int DATA_FIRST_BIT = 8;
  localparam int CMD_LAST_BIT   = 5;
  localparam int ADC_W          = 10;
  localparam int NUM_CH         = 8;
  localparam int AVG_N          = 4;
  localparam int ACC_W          = 12;
  localparam int CH_W           = 3;
  localparam int BIT_W          = 5;

  // Bit 1 = start, bit 2 = SGL, bits 3..5 = D2..D0, everything later is 0.
  function automatic logic cmd_bit(input logic [BIT_W-1:0] bit_num,
                                   input logic [CH_W-1:0]  ch);
    logic b;
    b = 1'b0;
    if (bit_num <= BIT_W'(CMD_LAST_BIT)) begin
      case (bit_num)
        5'd1, 5'd2: b = 1'b1;
        5'd3:       b = ch[2];
        5'd4:       b = ch[1];
        5'd5:       b = ch[0];
        default:    b = 1'b0;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/mcp3008_scanner_if.sv
// mcp3008_scanner_if
// Bundles the scanner's control, SPI pins and result outputs.
//   enable       : scan request (consumer -> scanner)
//   ad_clk/cs_n/din : SPI master outputs to the ADC
//   dout         : ADC serial data (ADC -> scanner)
//   sample_valid/sample_ch/sample_data : one-cycle result strobe + value
//   ch_data      : per-channel value bank, ch0 in [9:0]
//   busy         : frame or inter-frame gap in progress
// modport master = scanner side, modport slave = ADC/consumer side.
interface mcp3008_scanner_if;
  import mcp3008_pkg::*;

  logic                    enable;
  logic                    ad_clk;
  logic                    cs_n;
  logic                    din;
  logic                    dout;
  logic                    sample_valid;
  logic [CH_W-1:0]         sample_ch;
  logic [ADC_W-1:0]        sample_data;
  logic [NUM_CH*ADC_W-1:0] ch_data;
  logic                    busy;

  modport master (
    input  enable, dout,
    output ad_clk, cs_n, din, sample_valid, sample_ch, sample_data, ch_data, busy
  );

  modport slave (
    output enable, dout,
    input  ad_clk, cs_n, din, sample_valid, sample_ch, sample_data, ch_data, busy
  );

endinterface

// File: rtl/mcp3008_clkdiv.sv
// mcp3008_clkdiv
// Half-SCLK-period tick generator. Counts 0..HALF-1 and pulses tick on the
// last count; load restarts the count from 0.
//   clk, rst_n : system clock, async active-low reset
//   load       : restart counting (asserted on every FSM state entry)
//   tick       : high for one clock every HALF clocks
module mcp3008_clkdiv #(
  parameter int HALF = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mcp3008_scanner.sv
// mcp3008_scanner
// Free-running SPI master for the MCP3008: converts channels 0..7
// round-robin in single-ended mode, publishes each result as a one-cycle
// strobe and keeps a per-channel value bank.
//   clk, rst_n : system clock, async active-low reset
//   bus        : mcp3008_scanner_if.master (enable, SPI pins, results, busy)
// Parameters: CLK_FREQ_HZ, SCLK_HZ (<= 1.35 MHz), CS_IDLE_SCLK (>= 1).
// HALF = CLK_FREQ_HZ/(2*SCLK_HZ) must be >= 2.
// Build option: define MCP3008_AVG_EN to average 4 frames per channel.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cs_n high, waiting for enable
// ST_SETUP   | cs_n low, start bit on din, first half period before SCLK
// ST_SCLK_HI | ad_clk high; dout captured on entry for data bits
// ST_SCLK_LO | ad_clk low; din carries the next bit
// ST_GAP     | cs_n high for CS_IDLE_SCLK SCLK periods
// The falling edge of bit 17 goes straight from SCLK_HI to GAP so that
// cs_n rises on that same edge.
module mcp3008_scanner
  import mcp3008_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int SCLK_HZ      = 1_000_000,
  parameter int CS_IDLE_SCLK = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mcp3008_scanner_if.master   bus
);

  localparam int HALF      = CLK_FREQ_HZ / (2 * SCLK_HZ);
  localparam int GAP_TICKS = 2 * CS_IDLE_SCLK;
  localparam int GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_e             state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [CH_W-1:0]    ch_cnt;
  logic [ADC_W-1:0]   shreg;
  logic               pub_pend;
  logic [GAP_W-1:0]   gap_cnt;
  logic               div_tick;
  logic               div_load;
  logic               pub_last;
  logic [ADC_W-1:0]   pub_value;
  logic               hold_scan;

  // Every transition happens on a tick (which also wraps the divider),
  // so holding load in IDLE is enough to align the first half period.
  assign div_load = (state == ST_IDLE) || div_tick;

  mcp3008_clkdiv #(.HALF(HALF)) u_clkdiv (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (div_load),
    .tick  (div_tick)
  );

`ifdef MCP3008_AVG_EN
  logic [1:0]       avg_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] avg_sum;

  // The first frame of a channel starts a fresh sum.
  assign avg_sum   = ((avg_cnt == 2'd0) ? ACC_W'(0) : acc) + ACC_W'(shreg);
  assign pub_last  = (avg_cnt == 2'(AVG_N - 1));
  assign pub_value = avg_sum[ADC_W+1:2];
  // Keep converting until the current channel has all its frames.
  assign hold_scan = (avg_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_cnt <= '0;
      acc     <= '0;
    end else if (pub_pend) begin
      avg_cnt <= avg_cnt + 2'd1;
      acc     <= avg_sum;
    end
  end
`else
  assign pub_last  = 1'b1;
  assign pub_value = shreg;
  assign hold_scan = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      bit_cnt          <= '0;
      ch_cnt           <= '0;
      shreg            <= '0;
      pub_pend         <= 1'b0;
      gap_cnt          <= '0;
      bus.ad_clk       <= 1'b0;
      bus.cs_n         <= 1'b1;
      bus.din          <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.sample_ch    <= '0;
      bus.sample_data  <= '0;
      bus.ch_data      <= '0;
      bus.busy         <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;

      if (pub_pend) begin
        pub_pend <= 1'b0;
        if (pub_last) begin
          bus.sample_valid                       <= 1'b1;
          bus.sample_ch                          <= ch_cnt;
          bus.sample_data                        <= pub_value;
          bus.ch_data[ch_cnt*ADC_W +: ADC_W]     <= pub_value;
          ch_cnt                                 <= ch_cnt + 3'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          bus.ad_clk <= 1'b0;
          bus.cs_n   <= 1'b1;
          bus.din    <= 1'b0;
          if (bus.enable) begin
            state    <= ST_SETUP;
            bus.cs_n <= 1'b0;
            bus.din  <= cmd_bit(5'd1, ch_cnt);
            bus.busy <= 1'b1;
            bit_cnt  <= 5'd1;
          end
        end

        ST_SETUP: begin
          if (div_tick) begin
            state      <= ST_SCLK_HI;
            bus.ad_clk <= 1'b1;
          end
        end

        ST_SCLK_HI: begin
          if (div_tick) begin
            bus.ad_clk <= 1'b0;
            if (bit_cnt == BIT_W'(FRAME_BITS)) begin
              state    <= ST_GAP;
              bus.cs_n <= 1'b1;
              bus.din  <= 1'b0;
              gap_cnt  <= GAP_W'(GAP_TICKS - 1);
            end else begin
              state   <= ST_SCLK_LO;
              bit_cnt <= bit_cnt + 5'd1;
              bus.din <= cmd_bit(bit_cnt + 5'd1, ch_cnt);
            end
          end
        end

        ST_SCLK_LO: begin
          if (div_tick) begin
            state      <= ST_SCLK_HI;
            bus.ad_clk <= 1'b1;
            // dout was launched on the previous falling edge; take it as
            // SCLK rises.
            if (bit_cnt >= BIT_W'(DATA_FIRST_BIT)) begin
              shreg <= {shreg[ADC_W-2:0], bus.dout};
              if (bit_cnt == BIT_W'(FRAME_BITS)) begin
                pub_pend <= 1'b1;
              end
            end
          end
        end

        ST_GAP: begin
          if (div_tick) begin
            if (gap_cnt == '0) begin
              if (bus.enable || hold_scan) begin
                state    <= ST_SETUP;
                bus.cs_n <= 1'b0;
                bus.din  <= cmd_bit(5'd1, ch_cnt);
                bit_cnt  <= 5'd1;
              end else begin
                state    <= ST_IDLE;
                bus.busy <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
        end

        default: begin
          state      <= ST_IDLE;
          bus.ad_clk <= 1'b0;
          bus.cs_n   <= 1'b1;
          bus.din    <= 1'b0;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcp3008_scanner.sv
// tb_mcp3008_scanner
// Directed bench for mcp3008_scanner with a behavioural MCP3008 model and a
// scoreboard of expected {channel, value} results. Honours MCP3008_AVG_EN.
module tb_mcp3008_scanner;
  import mcp3008_pkg::*;

  localparam int HALF = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mcp3008_scanner_if bus();

  mcp3008_scanner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] ch;
    logic [9:0] data;
  } exp_t;
  exp_t sb[$];

  // ---------------- event recorder (just after each active edge)
  int unsigned cyc = 0;
  int unsigned fall_t = 0, prev_fall_t = 0, rise_t = 0, sv_t = 0;
  int unsigned first_rise_t = 0, last_rise_t = 0;
  int          n_rises = 0, bad_period = 0, n_frames = 0;
  logic        prev_cs = 1'b1, prev_ad = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (prev_cs && !bus.cs_n) begin
      prev_fall_t = fall_t;
      fall_t      = cyc;
      n_rises     = 0;
      bad_period  = 0;
      n_frames++;
    end
    if (!prev_cs && bus.cs_n) rise_t = cyc;
    if (!prev_ad && bus.ad_clk) begin
      if (n_rises == 0) first_rise_t = cyc;
      else if (cyc - last_rise_t != 2 * HALF) bad_period++;
      last_rise_t = cyc;
      n_rises++;
    end
    if (bus.sample_valid) sv_t = cyc;
    prev_cs = bus.cs_n;
    prev_ad = bus.ad_clk;
  end

  // ---------------- behavioural MCP3008
  int         mdl_rise = 0;
  logic [4:0] mdl_cmd  = '0;
  logic [4:0] last_cmd = '0;
  logic [9:0] mdl_word = '0;
  logic [9:0] ch5_val  = 10'h15A;
  int         ch0_frames = 0;
  logic [9:0] avg_seq [4] = '{10'd100, 10'd101, 10'd102, 10'd104};

  always @(negedge bus.cs_n) begin
    mdl_rise = 0;
    mdl_cmd  = '0;
  end

  always @(posedge bus.ad_clk) begin
    if (!bus.cs_n) begin
      mdl_rise++;
      if (mdl_rise <= 5) mdl_cmd = {mdl_cmd[3:0], bus.din};
      if (mdl_rise == 5) begin
        last_cmd = mdl_cmd;
        mdl_word = 10'h155 + 10'(mdl_cmd[2:0]);
        if (mdl_cmd[2:0] == 3'd5) mdl_word = ch5_val;
`ifdef MCP3008_AVG_EN
        if (mdl_cmd[2:0] == 3'd0 && ch0_frames < 4) mdl_word = avg_seq[ch0_frames];
        if (mdl_cmd[2:0] == 3'd0) ch0_frames++;
`endif
      end
    end
  end

  always @(negedge bus.ad_clk) begin
    if (!bus.cs_n) begin
      if (mdl_rise >= 7 && mdl_rise <= 16) bus.dout = mdl_word[16 - mdl_rise];
      else bus.dout = 1'b0;
    end
  end

  // ---------------- checking helpers
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.cs_n === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 80'(ok), 80'd1);
  endtask

  task automatic check_strobe(input string tag, input int budget);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.sample_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_strobe_seen"}, 80'(got), 80'd1);
    chk({tag, "_sb_nonempty"}, 80'(sb.size() > 0), 80'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_ch"},    80'(bus.sample_ch),   80'(e.ch));
      chk({tag, "_data"},  80'(bus.sample_data), 80'(e.data));
      chk({tag, "_bank"},  80'(bus.ch_data[e.ch*10 +: 10]), 80'(e.data));
      chk({tag, "_cmd"},   80'(last_cmd),        80'({2'b11, e.ch}));
      @(negedge clk);
      chk({tag, "_one_cycle"}, 80'(bus.sample_valid), 80'd0);
      chk({tag, "_hold"},  80'(bus.sample_data), 80'(e.data));
    end
  endtask

  function automatic logic [79:0] bank(input logic [9:0] v5);
    logic [79:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[c*10 +: 10] = 10'h155 + 10'(c);
    v[50 +: 10] = v5;
    return v;
  endfunction

  // ---------------- directed sequence
  initial begin
    int lows;
    int strobes;
    bus.enable = 1'b0;
    bus.dout   = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",  80'(bus.cs_n),         80'd1);
    chk("rst_adclk", 80'(bus.ad_clk),       80'd0);
    chk("rst_din",   80'(bus.din),          80'd0);
    chk("rst_sv",    80'(bus.sample_valid), 80'd0);
    chk("rst_ch",    80'(bus.sample_ch),    80'd0);
    chk("rst_data",  80'(bus.sample_data),  80'd0);
    chk("rst_bank",  bus.ch_data,           80'd0);
    chk("rst_busy",  80'(bus.busy),         80'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_cs_n", 80'(bus.cs_n), 80'd1);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("enable_latency", 80'(bus.cs_n), 80'd0);
    chk("busy_in_frame",  80'(bus.busy), 80'd1);

`ifdef MCP3008_AVG_EN
    sb.push_back('{ch: 3'd0, data: 10'd101});
    check_strobe("avg_ch0", 5000);
    chk("avg_frames_ch0", 80'(n_frames), 80'd4);
    chk("avg_sv_time",    80'(sv_t - fall_t), 80'(33 * HALF + 1));
    sb.push_back('{ch: 3'd1, data: 10'h156});
    check_strobe("avg_ch1", 5000);
    chk("avg_frames_ch1", 80'(n_frames), 80'd8);
`else
    for (int i = 0; i < 8; i++) sb.push_back('{ch: 3'(i), data: 10'h155 + 10'(i)});
    check_strobe("scan0", 2000);
    chk("sv_time",      80'(sv_t - fall_t), 80'(33 * HALF + 1));
    wait_cs(1'b1, "frame0_end");
    chk("cs_low_len",   80'(rise_t - fall_t), 80'(34 * HALF));
    chk("sclk_pulses",  80'(n_rises), 80'd17);
    chk("first_rise",   80'(first_rise_t - fall_t), 80'(HALF));
    chk("sclk_period",  80'(bad_period), 80'd0);
    wait_cs(1'b0, "frame1_start");
    chk("frame_period", 80'(fall_t - prev_fall_t), 80'(38 * HALF));
    for (int i = 1; i < 8; i++) check_strobe("scan", 2000);
    chk("bank_sweep", bus.ch_data, bank(10'h15A));

    // Stop mid-frame.
    wait_cs(1'b1, "stop_prev_end");
    wait_cs(1'b0, "stop_frame_start");
    repeat (399) @(negedge clk);
    bus.enable = 1'b0;
    sb.push_back('{ch: 3'd0, data: 10'h155});
    check_strobe("stop_frame", 2000);
    wait_cs(1'b1, "stop_frame_end");
    lows = 0;
    strobes = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.cs_n !== 1'b1) lows++;
      if (bus.sample_valid !== 1'b0) strobes++;
    end
    chk("stopped_cs_n",  80'(lows), 80'd0);
    chk("stopped_sv",    80'(strobes), 80'd0);
    chk("stopped_busy",  80'(bus.busy), 80'd0);
    chk("stopped_state", 80'(dut.state), 80'(ST_IDLE));
    bus.enable = 1'b1;
    sb.push_back('{ch: 3'd1, data: 10'h156});
    check_strobe("resume_ch1", 2000);

    // Extremes on channel 5.
    ch5_val = 10'h3FF;
    for (int i = 2; i < 8; i++)
      sb.push_back('{ch: 3'(i), data: (i == 5) ? 10'h3FF : 10'h155 + 10'(i)});
    for (int i = 2; i < 8; i++) check_strobe("ext_hi", 2000);
    chk("bank_ch5_3ff", bus.ch_data, bank(10'h3FF));
    ch5_val = 10'h000;
    for (int i = 0; i < 6; i++)
      sb.push_back('{ch: 3'(i), data: (i == 5) ? 10'h000 : 10'h155 + 10'(i)});
    for (int i = 0; i < 6; i++) check_strobe("ext_lo", 2000);
    chk("bank_ch5_000", bus.ch_data, bank(10'h000));

    // Reset mid-frame.
    wait_cs(1'b1, "rst_prev_end");
    wait_cs(1'b0, "rst_frame_start");
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n",  80'(bus.cs_n),         80'd1);
    chk("midrst_adclk", 80'(bus.ad_clk),       80'd0);
    chk("midrst_bank",  bus.ch_data,           80'd0);
    chk("midrst_busy",  80'(bus.busy),         80'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{ch: 3'd0, data: 10'h155});
    check_strobe("post_rst_ch0", 2000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
